// File: rtl/atp_pay_ctrl.sv
// Payment controller for a bill-payment kiosk: cash notes or a single cheque settle a scanned bill.
// Optional build macro ATP_TIMEOUT_EN adds an inactivity timeout in INFO/CASH/CHEQ.
module atp_pay_ctrl #(
   parameter int AMT_W       = 16,
   parameter int MAX_NOTES   = 32,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             scan,
   input  logic [AMT_W-1:0] bill_amt,
   input  logic [AMT_W-1:0] credit_in,
   input  logic             cash_sel,
   input  logic             cheq_sel,
   input  logic             note_valid,
   input  logic [AMT_W-1:0] note_val,
   output logic             note_ready,
   input  logic             cheq_valid,
   input  logic [AMT_W-1:0] cheq_amt,
   output logic             cheq_ready,
   input  logic             stop,
   output logic [AMT_W-1:0] bal_out,
   output logic [AMT_W-1:0] exc_out,
   output logic             note_rej,
   output logic             done,
   output logic             short_pay,
   output logic [2:0]       state_o
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_INFO  = 3'd1;
   localparam logic [2:0] S_CASH  = 3'd2;
   localparam logic [2:0] S_CHEQ  = 3'd3;
   localparam logic [2:0] S_SHORT = 3'd4;
   localparam logic [2:0] S_DONE  = 3'd5;

   localparam int N_DEN = 7;
   localparam logic [N_DEN-1:0][31:0] DENOM =
      {32'd1000, 32'd500, 32'd100, 32'd50, 32'd20, 32'd10, 32'd5};
   localparam int CNT_W = $clog2(MAX_NOTES + 1);

   logic [2:0]       state_reg, state_next;
   logic [AMT_W-1:0] bal_reg, bal_next;
   logic [AMT_W-1:0] exc_reg, exc_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic             rej_reg, rej_next;

   logic [N_DEN-1:0] den_hit;
   logic             note_legal;
   logic             note_hs;
   logic             cheq_hs;
   logic             note_cover;
   logic             cheq_cover;
   logic             cnt_full;
   logic             tmo_hit;

   genvar gi;
   generate
      for (gi = 0; gi < N_DEN; gi++) begin : g_den
         assign den_hit[gi] = (note_val == DENOM[gi][AMT_W-1:0]);
      end
   endgenerate

   assign note_legal = |den_hit;
   assign note_hs    = note_valid && note_ready;
   assign cheq_hs    = cheq_valid && cheq_ready;
   assign note_cover = (note_val >= bal_reg);
   assign cheq_cover = (cheq_amt >= bal_reg);
   // One more legal, non-settling note makes the count reach the cap.
   assign cnt_full   = (cnt_reg == CNT_W'(MAX_NOTES - 1));

`ifdef ATP_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
   logic [TMO_W-1:0] tmo_reg;
   logic             wait_st;

   assign wait_st = (state_reg == S_INFO) || (state_reg == S_CASH) || (state_reg == S_CHEQ);
   assign tmo_hit = wait_st && !note_hs && !cheq_hs && (tmo_reg == TMO_W'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk) begin
      if (!rst || !wait_st || note_hs || cheq_hs || (state_next != state_reg))
         tmo_reg <= '0;
      else
         tmo_reg <= tmo_reg + TMO_W'(1);
   end
`else
   assign tmo_hit = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst)
         state_reg <= S_IDLE;
      else
         state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE: begin
            if (scan)
               state_next = (bill_amt > credit_in) ? S_INFO : S_DONE;
         end
         S_INFO: begin
            if (cash_sel)
               state_next = S_CASH;
            else if (cheq_sel)
               state_next = S_CHEQ;
            else if (tmo_hit)
               state_next = S_IDLE;
         end
         S_CASH: begin
            // A note offered together with stop is applied before stop is honoured.
            if (note_hs && note_legal) begin
               if (note_cover)
                  state_next = S_DONE;
               else if (stop || cnt_full)
                  state_next = S_SHORT;
            end else if (stop || tmo_hit) begin
               state_next = S_SHORT;
            end
         end
         S_CHEQ: begin
            if (cheq_hs)
               state_next = cheq_cover ? S_DONE : S_SHORT;
            else if (tmo_hit)
               state_next = S_SHORT;
         end
         S_SHORT, S_DONE: state_next = S_IDLE;
         default:         state_next = S_IDLE;
      endcase
   end

   always_comb begin
      note_ready = 1'b0;
      cheq_ready = 1'b0;
      done       = 1'b0;
      short_pay  = 1'b0;
      case (state_reg)
         S_CASH:  note_ready = 1'b1;
         S_CHEQ:  cheq_ready = 1'b1;
         S_SHORT: short_pay  = 1'b1;
         S_DONE:  done       = 1'b1;
         default: ;
      endcase
   end

   // Every subtraction is guarded by a compare, so no result can wrap.
   always_comb begin
      bal_next = bal_reg;
      exc_next = exc_reg;
      cnt_next = cnt_reg;
      rej_next = 1'b0;
      case (state_reg)
         S_IDLE: begin
            if (scan) begin
               cnt_next = '0;
               if (bill_amt > credit_in) begin
                  bal_next = bill_amt - credit_in;
                  exc_next = '0;
               end else begin
                  bal_next = '0;
                  exc_next = credit_in - bill_amt;
               end
            end
         end
         S_CASH: begin
            if (note_hs) begin
               if (!note_legal) begin
                  rej_next = 1'b1;
               end else if (note_cover) begin
                  exc_next = note_val - bal_reg;
                  bal_next = '0;
               end else begin
                  bal_next = bal_reg - note_val;
                  cnt_next = cnt_reg + CNT_W'(1);
               end
            end
         end
         S_CHEQ: begin
            if (cheq_hs) begin
               if (cheq_cover) begin
                  exc_next = cheq_amt - bal_reg;
                  bal_next = '0;
               end else begin
                  bal_next = bal_reg - cheq_amt;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         bal_reg <= '0;
         exc_reg <= '0;
         cnt_reg <= '0;
         rej_reg <= 1'b0;
      end else begin
         bal_reg <= bal_next;
         exc_reg <= exc_next;
         cnt_reg <= cnt_next;
         rej_reg <= rej_next;
      end
   end

   assign bal_out  = bal_reg;
   assign exc_out  = exc_reg;
   assign note_rej = rej_reg;
   assign state_o  = state_reg;

endmodule

// File: tb/tb_atp_pay_ctrl.sv
// Bench for atp_pay_ctrl: directed vector table, hand sequences, and randomized transactions
// checked against a transaction-level payment model.
module tb_atp_pay_ctrl;

   localparam int AMT_W = 16;
   localparam int MAXN  = 4;
   localparam int TMO   = 16;

   logic             clk;
   logic             rst;
   logic             scan;
   logic [AMT_W-1:0] bill_amt;
   logic [AMT_W-1:0] credit_in;
   logic             cash_sel;
   logic             cheq_sel;
   logic             note_valid;
   logic [AMT_W-1:0] note_val;
   logic             note_ready;
   logic             cheq_valid;
   logic [AMT_W-1:0] cheq_amt;
   logic             cheq_ready;
   logic             stop;
   logic [AMT_W-1:0] bal_out;
   logic [AMT_W-1:0] exc_out;
   logic             note_rej;
   logic             done;
   logic             short_pay;
   logic [2:0]       state_o;

   atp_pay_ctrl #(.AMT_W(AMT_W), .MAX_NOTES(MAXN), .TIMEOUT_CYC(TMO)) dut (
      .clk(clk), .rst(rst), .scan(scan), .bill_amt(bill_amt), .credit_in(credit_in),
      .cash_sel(cash_sel), .cheq_sel(cheq_sel), .note_valid(note_valid), .note_val(note_val),
      .note_ready(note_ready), .cheq_valid(cheq_valid), .cheq_amt(cheq_amt),
      .cheq_ready(cheq_ready), .stop(stop), .bal_out(bal_out), .exc_out(exc_out),
      .note_rej(note_rej), .done(done), .short_pay(short_pay), .state_o(state_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int rej_cnt = 0;

   always @(negedge clk) if (note_rej === 1'b1) rej_cnt++;

   typedef struct packed {
      logic [15:0]      bill;
      logic [15:0]      credit;
      logic             cheq;
      logic [3:0]       n;
      logic [5:0][15:0] notes;
      logic             stop;
      logic             sep;
      logic             gap;
      logic             x_done;
      logic [15:0]      x_bal;
      logic [15:0]      x_exc;
      logic [3:0]       x_rej;
   } txn_t;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic bit is_legal(input int v);
      return (v == 5) || (v == 10) || (v == 20) || (v == 50) ||
             (v == 100) || (v == 500) || (v == 1000);
   endfunction

   // Transaction-level model: walks the offered notes with plain integer arithmetic and
   // decides how many are actually taken and how the transaction ends.
   function automatic txn_t model(input txn_t t);
      txn_t r;
      int bal, exc, cnt, rej, v;
      bit fin;
      r = t;
      bal = (t.bill > t.credit) ? int'(t.bill) - int'(t.credit) : 0;
      exc = (t.bill > t.credit) ? 0 : int'(t.credit) - int'(t.bill);
      cnt = 0; rej = 0; fin = 0;
      if (bal == 0) begin
         r.n = 0; r.stop = 0; r.x_done = 1'b1;
      end else if (t.cheq) begin
         v = int'(t.notes[0]);
         r.n = 1;
         if (v >= bal) begin exc = v - bal; bal = 0; r.x_done = 1'b1; end
         else begin bal = bal - v; r.x_done = 1'b0; end
      end else begin
         for (int i = 0; i < int'(t.n) && !fin; i++) begin
            v = int'(t.notes[i]);
            if (!is_legal(v)) begin
               rej++;
            end else if (v >= bal) begin
               exc = v - bal; bal = 0; fin = 1; r.x_done = 1'b1;
               r.n = 4'(i + 1); r.sep = 1'b0;
            end else begin
               bal = bal - v; cnt++;
               if (cnt == MAXN) begin
                  fin = 1; r.x_done = 1'b0; r.n = 4'(i + 1); r.sep = 1'b0;
               end
            end
         end
         if (!fin) begin
            r.x_done = 1'b0; r.stop = 1'b1;
         end
      end
      r.x_bal = 16'(bal);
      r.x_exc = 16'(exc);
      r.x_rej = 4'(rej);
      return r;
   endfunction

   function automatic txn_t mk(input int bill, credit, input bit cq, input int n,
                               input int a, b, c, d, e, input bit st, sp,
                               input bit xd, input int xb, xe, xr);
      txn_t t;
      t = '0;
      t.bill = 16'(bill); t.credit = 16'(credit); t.cheq = cq; t.n = 4'(n);
      t.notes[0] = 16'(a); t.notes[1] = 16'(b); t.notes[2] = 16'(c);
      t.notes[3] = 16'(d); t.notes[4] = 16'(e);
      t.stop = st; t.sep = sp; t.x_done = xd;
      t.x_bal = 16'(xb); t.x_exc = 16'(xe); t.x_rej = 4'(xr);
      return t;
   endfunction

   task automatic run_txn(input txn_t t, input string nm);
      int k;
      logic ok, a_done, a_short;
      logic [15:0] a_bal, a_exc;
      rej_cnt = 0;
      scan = 1'b1; bill_amt = t.bill; credit_in = t.credit;
      tick();
      scan = 1'b0;
      if (t.bill > t.credit) begin
         if (t.cheq) cheq_sel = 1'b1; else cash_sel = 1'b1;
         tick();
         cash_sel = 1'b0; cheq_sel = 1'b0;
         if (t.cheq) begin
            cheq_valid = 1'b1; cheq_amt = t.notes[0];
            tick();
            cheq_valid = 1'b0;
         end else begin
            for (int i = 0; i < int'(t.n); i++) begin
               note_valid = 1'b1; note_val = t.notes[i];
               stop = t.stop && !t.sep && (i == int'(t.n) - 1);
               tick();
               note_valid = 1'b0; stop = 1'b0;
               if (t.gap && i != int'(t.n) - 1) tick();
            end
            if (t.stop && (t.sep || t.n == 0)) begin
               stop = 1'b1;
               tick();
               stop = 1'b0;
            end
         end
      end
      k = 0;
      while (!(done === 1'b1 || short_pay === 1'b1) && k < 8) begin
         tick();
         k++;
      end
      ok = (done === 1'b1 || short_pay === 1'b1);
      a_done = done; a_short = short_pay; a_bal = bal_out; a_exc = exc_out;
      chk({nm, " completes"}, 32'(ok), 32'd1);
      chk({nm, " done"}, 32'(a_done), 32'(t.x_done));
      chk({nm, " short_pay"}, 32'(a_short), 32'(!t.x_done));
      chk({nm, " bal_out"}, 32'(a_bal), 32'(t.x_bal));
      chk({nm, " exc_out"}, 32'(a_exc), 32'(t.x_exc));
      tick();
      chk({nm, " back to idle"}, 32'(state_o), 32'd0);
      chk({nm, " pulse ended"}, 32'(done | short_pay), 32'd0);
      chk({nm, " note_rej count"}, 32'(rej_cnt), 32'(t.x_rej));
      tick();
      chk({nm, " hold bal"}, 32'(bal_out), 32'(t.x_bal));
      chk({nm, " hold exc"}, 32'(exc_out), 32'(t.x_exc));
      $display("txn %s bill=%0d credit=%0d mode=%s taken=%0d -> %s bal=%0d exc=%0d rej=%0d",
               nm, t.bill, t.credit, t.cheq ? "cheq" : "cash", t.n,
               a_done ? "done" : "short", a_bal, a_exc, rej_cnt);
   endtask

   txn_t vec[13];
   int   pool[10] = '{5, 10, 20, 50, 100, 500, 1000, 7, 30, 200};

   initial begin
      txn_t t;
      vec[0]  = mk(100,  0,   0, 3, 50, 20, 50, 0, 0, 0, 0, 1, 0,   20,  0);
      vec[1]  = mk(100,  0,   0, 1, 30, 0,  0,  0, 0, 1, 1, 0, 100, 0,   1);
      vec[2]  = mk(500,  600, 0, 0, 0,  0,  0,  0, 0, 0, 0, 1, 0,   100, 0);
      vec[3]  = mk(1000, 0,   1, 1, 700, 0, 0,  0, 0, 0, 0, 0, 300, 0,   0);
      vec[4]  = mk(1000, 0,   1, 1, 1200, 0, 0, 0, 0, 0, 0, 1, 0,   200, 0);
      vec[5]  = mk(100,  0,   0, 1, 100, 0, 0,  0, 0, 1, 0, 1, 0,   0,   0);
      vec[6]  = mk(100,  0,   0, 4, 5,  5,  5,  5, 0, 0, 0, 0, 80,  0,   0);
      vec[7]  = mk(250,  250, 0, 0, 0,  0,  0,  0, 0, 0, 0, 1, 0,   0,   0);
      vec[8]  = mk(70,   0,   0, 2, 20, 50, 0,  0, 0, 0, 0, 1, 0,   0,   0);
      vec[9]  = mk(100,  0,   0, 1, 20, 0,  0,  0, 0, 1, 0, 0, 80,  0,   0);
      vec[10] = mk(100,  0,   0, 5, 5,  7,  5,  5, 5, 0, 0, 0, 80,  0,   1);
      vec[11] = mk(300,  100, 1, 1, 200, 0, 0,  0, 0, 0, 0, 1, 0,   0,   0);
      vec[12] = mk(300,  120, 0, 2, 100, 100, 0, 0, 0, 0, 0, 1, 0,  20,  0);

      rst = 1'b0; scan = 1'b0; bill_amt = '0; credit_in = '0; cash_sel = 1'b0;
      cheq_sel = 1'b0; note_valid = 1'b0; note_val = '0; cheq_valid = 1'b0;
      cheq_amt = '0; stop = 1'b0;
      repeat (3) tick();
      chk("reset state", 32'(state_o), 32'd0);
      chk("reset bal", 32'(bal_out), 32'd0);
      chk("reset exc", 32'(exc_out), 32'd0);
      chk("reset outputs", 32'({note_ready, cheq_ready, done, short_pay, note_rej}), 32'd0);
      rst = 1'b1;
      tick();

      for (int i = 0; i < 13; i++) run_txn(vec[i], $sformatf("vec%0d", i));

      // Step-by-step cash payment with per-note balance visibility.
      scan = 1'b1; bill_amt = 16'd100; credit_in = 16'd0;
      tick(); scan = 1'b0;
      chk("seq info state", 32'(state_o), 32'd1);
      tick();
      chk("seq info holds", 32'(state_o), 32'd1);
      cash_sel = 1'b1; cheq_sel = 1'b1;
      tick(); cash_sel = 1'b0; cheq_sel = 1'b0;
      chk("seq cash wins", 32'(state_o), 32'd2);
      chk("seq note_ready", 32'(note_ready), 32'd1);
      note_valid = 1'b1; note_val = 16'd50; tick();
      chk("seq bal after 50", 32'(bal_out), 32'd50);
      note_val = 16'd20; tick();
      chk("seq bal after 20", 32'(bal_out), 32'd30);
      note_val = 16'd50; tick(); note_valid = 1'b0;
      chk("seq bal after 50b", 32'(bal_out), 32'd0);
      chk("seq exc", 32'(exc_out), 32'd20);
      chk("seq done", 32'(done), 32'd1);
      tick();

      // Scan clears excess; illegal note pulse timing; reset mid-CASH discards a handshake.
      scan = 1'b1; bill_amt = 16'd300; credit_in = 16'd100;
      tick(); scan = 1'b0;
      chk("scan clears exc", 32'(exc_out), 32'd0);
      chk("scan bal", 32'(bal_out), 32'd200);
      cash_sel = 1'b1; tick(); cash_sel = 1'b0;
      note_valid = 1'b1; note_val = 16'd30; tick(); note_valid = 1'b0;
      chk("rej pulse", 32'(note_rej), 32'd1);
      chk("rej bal kept", 32'(bal_out), 32'd200);
      tick();
      chk("rej pulse one cycle", 32'(note_rej), 32'd0);
      rst = 1'b0; note_valid = 1'b1; note_val = 16'd500;
      tick();
      chk("midreset state", 32'(state_o), 32'd0);
      chk("midreset bal", 32'(bal_out), 32'd0);
      chk("midreset exc", 32'(exc_out), 32'd0);
      chk("midreset outputs", 32'({note_ready, cheq_ready, done, short_pay, note_rej}), 32'd0);
      rst = 1'b1; note_valid = 1'b0;
      tick();
      chk("handshake discarded", 32'(state_o), 32'd0);

      scan = 1'b1; bill_amt = 16'd100; credit_in = 16'd0;
      tick(); scan = 1'b0;
      cash_sel = 1'b1; tick(); cash_sel = 1'b0;
`ifdef ATP_TIMEOUT_EN
      repeat (TMO - 1) tick();
      chk("tmo still cash", 32'(state_o), 32'd2);
      tick();
      chk("tmo short_pay", 32'(short_pay), 32'd1);
      chk("tmo bal", 32'(bal_out), 32'd100);
      tick();
      chk("tmo idle", 32'(state_o), 32'd0);
`else
      repeat (40) tick();
      chk("no timeout cash", 32'(state_o), 32'd2);
      stop = 1'b1; tick(); stop = 1'b0;
      chk("stop short_pay", 32'(short_pay), 32'd1);
      tick();
`endif

      for (int r = 0; r < 40; r++) begin
         t = '0;
         t.bill = 16'($urandom_range(1, 3000));
         t.credit = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 3000)) : 16'd0;
         t.cheq = ($urandom_range(0, 3) == 0);
         t.n = 4'($urandom_range(0, 6));
         for (int i = 0; i < 6; i++) t.notes[i] = 16'(pool[$urandom_range(0, 9)]);
         if (t.cheq) t.notes[0] = 16'($urandom_range(1, 3000));
         t.stop = 1'($urandom_range(0, 1));
         t.sep = 1'($urandom_range(0, 1));
         t.gap = 1'($urandom_range(0, 1));
         t = model(t);
         run_txn(t, $sformatf("rnd%0d", r));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
